// File: rtl/chi_txflit_rd_arb.sv
// Round-robin share of one flit-RAM read port among NUM_CH CHI TX channels.
// Grant registered one clock after request; data returned RD_LAT+1 clocks after the RAM strobe.
module chi_txflit_rd_arb #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        ch_rd_req_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr_i,
  input  logic [NUM_CH-1:0]        ch_clear_i,
  output logic [NUM_CH-1:0]        ch_rd_valid_o,
  output logic [DATA_W-1:0]        ch_rd_data_o,
  output logic [NUM_CH-1:0]        ch_busy_o,
  output logic                     mem_rd_en_o,
  output logic [CH_W+ADDR_W-1:0]   mem_rd_addr_o,
  input  logic [DATA_W-1:0]        mem_rd_data_i,
  output logic                     err_overrun_o
);

  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [CH_W-1:0]               ptr_q, ptr_d;
  logic                          mem_en_q;
  logic [CH_W+ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic                          pipe_vld_q [RD_LAT];
  logic [CH_W-1:0]               pipe_ch_q  [RD_LAT];
  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [DATA_W-1:0]             data_q;
  logic                          err_q, err_d;

  logic [NUM_CH-1:0]             old_v, elig, gnt_oh;
  logic [NUM_CH-1:0][ADDR_W-1:0] sel_addr;
  logic                          gnt_vld;
  logic [CH_W-1:0]               gnt_idx;
  logic [CH_W:0]                 scan_idx;
  logic [CH_W-1:0]               mem_ch, tail_ch;
  logic                          tail_vld;

  assign mem_ch   = mem_addr_q[ADDR_W +: CH_W];
  assign tail_vld = pipe_vld_q[RD_LAT-1];
  assign tail_ch  = pipe_ch_q[RD_LAT-1];

  // A clear only drops the stored request; a same-cycle new request stays eligible.
  always_comb begin
    old_v    = '0;
    elig     = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      old_v[i]    = pend_q[i] & ~ch_clear_i[i];
      elig[i]     = old_v[i] | ch_rd_req_i[i];
      sel_addr[i] = old_v[i] ? addr_q[i] : ch_rd_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // Scan downward so the closest eligible channel at/after the pointer wins last.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (scan_idx >= (CH_W+1)'(NUM_CH))
        scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      if (elig[scan_idx[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    pend_d = '0;
    addr_d = addr_q;
    err_d  = err_q;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == CH_W'(i));
      pend_d[i] = gnt_oh[i] ? (old_v[i] & ch_rd_req_i[i]) : (old_v[i] | ch_rd_req_i[i]);
      if (ch_rd_req_i[i] && (!old_v[i] || gnt_oh[i]))
        addr_d[i] = ch_rd_addr_i[i*ADDR_W +: ADDR_W];
      if (old_v[i] && ch_rd_req_i[i] && !gnt_oh[i])
        err_d = 1'b1;
    end
    ptr_d      = ptr_q;
    mem_addr_d = mem_addr_q;
    if (gnt_vld) begin
      ptr_d      = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
      mem_addr_d = {gnt_idx, sel_addr[gnt_idx]};
    end
    valid_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      valid_d[i] = tail_vld && (tail_ch == CH_W'(i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      addr_q     <= '0;
      ptr_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_ch_q[k]  <= '0;
      end
      valid_q    <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      ptr_q         <= ptr_d;
      mem_en_q      <= gnt_vld;
      mem_addr_q    <= mem_addr_d;
      pipe_vld_q[0] <= mem_en_q;
      pipe_ch_q[0]  <= mem_ch;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_ch_q[k]  <= pipe_ch_q[k-1];
      end
      valid_q       <= valid_d;
      if (tail_vld)
        data_q <= mem_rd_data_i;
      err_q         <= err_d;
    end
  end

  always_comb begin
    ch_busy_o = pend_q | valid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mem_en_q && (mem_ch == CH_W'(i)))
        ch_busy_o[i] = 1'b1;
      for (int k = 0; k < RD_LAT; k++)
        if (pipe_vld_q[k] && (pipe_ch_q[k] == CH_W'(i)))
          ch_busy_o[i] = 1'b1;
    end
  end

  assign ch_rd_valid_o = valid_q;
  assign ch_rd_data_o  = data_q;
  assign mem_rd_en_o   = mem_en_q;
  assign mem_rd_addr_o = mem_addr_q;
  assign err_overrun_o = err_q;

endmodule

// File: tb/tb_chi_txflit_rd_arb.sv
// Directed bench for chi_txflit_rd_arb: a 2-cycle RAM model returns data derived from the read address.
module tb_chi_txflit_rd_arb;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 256;
  localparam int RD_LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_rd_req = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr = '0;
  logic [NUM_CH-1:0]        ch_clear = '0;
  logic [NUM_CH-1:0]        ch_rd_valid;
  logic [DATA_W-1:0]        ch_rd_data;
  logic [NUM_CH-1:0]        ch_busy;
  logic                     mem_rd_en;
  logic [CH_W+ADDR_W-1:0]   mem_rd_addr;
  logic [DATA_W-1:0]        mem_rd_data;
  logic                     err_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_CH-1:0] seen;

  chi_txflit_rd_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .ch_rd_req_i(ch_rd_req), .ch_rd_addr_i(ch_rd_addr),
    .ch_clear_i(ch_clear), .ch_rd_valid_o(ch_rd_valid), .ch_rd_data_o(ch_rd_data),
    .ch_busy_o(ch_busy), .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_data_i(mem_rd_data), .err_overrun_o(err_overrun)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] fdata(input logic [CH_W+ADDR_W-1:0] a);
    return {8{24'hC0DE00, 2'b00, a}};
  endfunction

  logic [DATA_W-1:0] ram_s0, ram_s1;
  always @(posedge clk) begin
    ram_s0 <= mem_rd_en ? fdata(mem_rd_addr) : '0;
    ram_s1 <= ram_s0;
  end
  assign mem_rd_data = ram_s1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_en", mem_rd_en, 0);
    chk("rst_valid", ch_rd_valid, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_data", ch_rd_data, 0);
    rst = 1'b0;
    tick();

    // single read, ch1 addr 5
    ch_rd_req = 3'b010; ch_rd_addr = {4'd0, 4'd5, 4'd0};
    chk("t1_busy_t0", ch_busy, 3'b000);
    tick(); ch_rd_req = '0;
    chk("t1_en", mem_rd_en, 1);
    chk("t1_addr", mem_rd_addr, 6'h15);
    chk("t1_busy_t1", ch_busy, 3'b010);
    tick();
    chk("t1_en_t2", mem_rd_en, 0);
    tick();
    chk("t1_valid_t3", ch_rd_valid, 3'b000);
    chk("t1_busy_t3", ch_busy, 3'b010);
    tick();
    chk("t1_valid_t4", ch_rd_valid, 3'b010);
    chk("t1_data", ch_rd_data, fdata(6'h15));
    chk("t1_busy_t4", ch_busy, 3'b010);
    tick();
    chk("t1_valid_t5", ch_rd_valid, 3'b000);
    chk("t1_busy_t5", ch_busy, 3'b000);

    // all three at once from pointer 0
    do_reset();
    ch_rd_req = 3'b111; ch_rd_addr = {4'd3, 4'd2, 4'd1};
    tick(); ch_rd_req = '0;
    chk("t2_g0", mem_rd_addr, 6'h01);
    tick();
    chk("t2_g1", mem_rd_addr, 6'h12);
    tick();
    chk("t2_g2", mem_rd_addr, 6'h23);
    chk("t2_en_g2", mem_rd_en, 1);
    tick();
    chk("t2_en_off", mem_rd_en, 0);
    chk("t2_v0", ch_rd_valid, 3'b001);
    chk("t2_d0", ch_rd_data, fdata(6'h01));
    tick();
    chk("t2_v1", ch_rd_valid, 3'b010);
    chk("t2_d1", ch_rd_data, fdata(6'h12));
    tick();
    chk("t2_v2", ch_rd_valid, 3'b100);
    chk("t2_d2", ch_rd_data, fdata(6'h23));
    ch_rd_req = 3'b111; ch_rd_addr = {4'd6, 4'd5, 4'd4};
    tick(); ch_rd_req = '0;
    chk("t2_b2_first", mem_rd_addr, 6'h04);
    tick();
    chk("t2_b2_second", mem_rd_addr, 6'h15);
    repeat (6) tick();

    // fairness: ch0 and ch2 re-request right after each grant
    ch_rd_req = 3'b101; ch_rd_addr = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t3_en", mem_rd_en, 1);
      chk("t3_ch", mem_rd_addr[5:4], (k % 2 == 0) ? 2'd0 : 2'd2);
      ch_rd_req = (mem_rd_addr[5:4] == 2'd0) ? 3'b001 : 3'b100;
    end
    ch_rd_req = '0;
    repeat (6) tick();
    chk("t3_no_err", err_overrun, 0);

    // overrun: ch0 blocked behind ch1/ch2
    do_reset();
    ch_rd_req = 3'b001; ch_rd_addr = {4'd0, 4'd0, 4'd1};
    tick();
    ch_rd_req = 3'b111; ch_rd_addr = {4'd9, 4'd8, 4'd3};
    tick();
    ch_rd_req = 3'b001; ch_rd_addr = {4'd0, 4'd0, 4'd7};
    chk("t4_g1", mem_rd_addr, 6'h18);
    chk("t4_err_before", err_overrun, 0);
    tick(); ch_rd_req = '0;
    chk("t4_g2", mem_rd_addr, 6'h29);
    chk("t4_err_set", err_overrun, 1);
    tick();
    chk("t4_g0_addr3", mem_rd_addr, 6'h03);
    tick();
    chk("t4_addr7_dropped", mem_rd_en, 0);
    repeat (6) tick();
    chk("t4_err_sticky", err_overrun, 1);

    // clear before grant (pointer at 1): ch2 never issued
    ch_rd_req = 3'b110; ch_rd_addr = {4'd5, 4'd4, 4'd0};
    tick(); ch_rd_req = '0; ch_clear = 3'b100;
    chk("t5_g1", mem_rd_addr, 6'h14);
    chk("t5_busy_pend", ch_busy, 3'b110);
    tick(); ch_clear = '0;
    chk("t5_no_grant", mem_rd_en, 0);
    chk("t5_busy_cleared", ch_busy, 3'b010);
    repeat (4) tick();
    // clear after grant: data still returns
    ch_rd_req = 3'b010; ch_rd_addr = {4'd0, 4'hA, 4'd0};
    tick(); ch_rd_req = '0; ch_clear = 3'b010;
    chk("t5_g1b", mem_rd_addr, 6'h1A);
    tick(); ch_clear = '0;
    tick();
    tick();
    chk("t5_late_valid", ch_rd_valid, 3'b010);
    chk("t5_late_data", ch_rd_data, fdata(6'h1A));
    repeat (3) tick();

    // async reset with two reads in flight
    ch_rd_req = 3'b011; ch_rd_addr = {4'd0, 4'd3, 4'd2};
    tick(); ch_rd_req = '0;
    tick();
    chk("t6_inflight", mem_rd_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_en", mem_rd_en, 0);
    chk("t6_rst_busy", ch_busy, 0);
    chk("t6_rst_valid", ch_rd_valid, 0);
    chk("t6_rst_err", err_overrun, 0);
    tick();
    rst = 1'b0;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | ch_rd_valid;
    end
    chk("t6_no_stale_valid", seen, 0);
    ch_rd_req = 3'b110; ch_rd_addr = {4'd2, 4'd1, 4'd0};
    tick(); ch_rd_req = '0;
    chk("t6_post_g1", mem_rd_addr, 6'h11);
    tick();
    chk("t6_post_g2", mem_rd_addr, 6'h22);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
